// File: rtl/raster_pkg.sv
// Shared raster types and tile-field widths used by the binner and the rasterizer.
package raster_pkg;

  localparam int COORD_W  = 10;
  localparam int Z_W      = 8;
  localparam int COLOR_W  = 4;
  localparam int TILE_X_W = 5;
  localparam int TILE_Y_W = 4;

  localparam int TILE_WIDTH_DFLT   = 32;
  localparam int TILE_COLUMNS_DFLT = 20;
  localparam int TILE_ROWS_DFLT    = 15;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [Z_W-1:0]     z;
  } coord_3d_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_2d_t;

  typedef struct packed {
    logic [COLOR_W-1:0]  color;
    logic [2:0]          padding;
    logic [TILE_Y_W-1:0] tile_y;
    logic [TILE_X_W-1:0] tile_x;
  } polygon_t;

  typedef enum logic [1:0] {IDLE, SETUP, EMIT} binner_state_t;

endpackage

// File: rtl/tile_bbox.sv
// Combinational bounding box, tile clamp and cull decision for one triangle.
// BINNER_BACKFACE_CULL_EN adds a signed-area test that rejects area <= 0.
module tile_bbox
  import raster_pkg::*;
#(
  parameter int TILE_WIDTH   = 32,
  parameter int TILE_COLUMNS = 20,
  parameter int TILE_ROWS    = 15
) (
  input  coord_2d_t             p0,
  input  coord_2d_t             p1,
  input  coord_2d_t             p2,
  output logic [TILE_X_W-1:0]   min_tx,
  output logic [TILE_X_W-1:0]   max_tx,
  output logic [TILE_Y_W-1:0]   min_ty,
  output logic [TILE_Y_W-1:0]   max_ty,
  output logic                  cull
);

  localparam int SHIFT = $clog2(TILE_WIDTH);
  localparam logic [COORD_W-1:0] LAST_TX  = COORD_W'(TILE_COLUMNS - 1);
  localparam logic [COORD_W-1:0] LAST_TY  = COORD_W'(TILE_ROWS - 1);
  localparam logic [COORD_W:0]   SCREEN_W = (COORD_W+1)'(TILE_WIDTH * TILE_COLUMNS);
  localparam logic [COORD_W:0]   SCREEN_H = (COORD_W+1)'(TILE_WIDTH * TILE_ROWS);

  function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a, b, c);
    logic [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a, b, c);
    logic [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic [COORD_W-1:0] sat_tile(input logic [COORD_W-1:0] t,
                                                  input logic [COORD_W-1:0] last);
    return (t > last) ? last : t;
  endfunction

`ifdef BINNER_BACKFACE_CULL_EN
  function automatic logic signed [22:0] signed_area(input coord_2d_t a, b, c);
    logic signed [10:0] dx1, dy1, dx2, dy2;
    logic signed [21:0] prod1, prod2;
    dx1   = $signed({1'b0, b.x}) - $signed({1'b0, a.x});
    dy1   = $signed({1'b0, b.y}) - $signed({1'b0, a.y});
    dx2   = $signed({1'b0, c.x}) - $signed({1'b0, a.x});
    dy2   = $signed({1'b0, c.y}) - $signed({1'b0, a.y});
    prod1 = dx1 * dy2;
    prod2 = dx2 * dy1;
    return $signed({prod1[21], prod1}) - $signed({prod2[21], prod2});
  endfunction
`endif

  logic [COORD_W-1:0] min_x, max_x, min_y, max_y;
  logic               off_screen;

  always_comb begin
    min_x      = min3(p0.x, p1.x, p2.x);
    max_x      = max3(p0.x, p1.x, p2.x);
    min_y      = min3(p0.y, p1.y, p2.y);
    max_y      = max3(p0.y, p1.y, p2.y);
    min_tx     = TILE_X_W'(min_x >> SHIFT);
    min_ty     = TILE_Y_W'(min_y >> SHIFT);
    max_tx     = TILE_X_W'(sat_tile(max_x >> SHIFT, LAST_TX));
    max_ty     = TILE_Y_W'(sat_tile(max_y >> SHIFT, LAST_TY));
    off_screen = ({1'b0, min_x} >= SCREEN_W) || ({1'b0, min_y} >= SCREEN_H);
`ifdef BINNER_BACKFACE_CULL_EN
    cull       = off_screen || (signed_area(p0, p1, p2) <= 23'sd0);
`else
    cull       = off_screen;
`endif
  end

endmodule

// File: rtl/tile_binner.sv
// Triangle-to-tile binner: one record per tile covered by the triangle bbox, raster order.
// Optional back-face culling via BINNER_BACKFACE_CULL_EN (see tile_bbox).
module tile_binner
  import raster_pkg::*;
#(
  parameter int TILE_WIDTH   = TILE_WIDTH_DFLT,
  parameter int TILE_COLUMNS = TILE_COLUMNS_DFLT,
  parameter int TILE_ROWS    = TILE_ROWS_DFLT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_vld,
  output logic               in_rdy,
  input  coord_3d_t          in_v0,
  input  coord_3d_t          in_v1,
  input  coord_3d_t          in_v2,
  input  logic [COLOR_W-1:0] in_color,
  output logic               out_vld,
  input  logic               out_rdy,
  output coord_3d_t          out_v0,
  output coord_3d_t          out_v1,
  output coord_3d_t          out_v2,
  output polygon_t           out_meta,
  output logic               tri_done
);

  binner_state_t       state;
  coord_2d_t           p0, p1, p2;
  logic [TILE_X_W-1:0] min_tx, max_tx, min_tx_r, max_tx_r;
  logic [TILE_Y_W-1:0] min_ty, max_ty, max_ty_r;
  logic                cull;
  logic                last_x, last_y;

  assign p0 = '{x: out_v0.x, y: out_v0.y};
  assign p1 = '{x: out_v1.x, y: out_v1.y};
  assign p2 = '{x: out_v2.x, y: out_v2.y};

  tile_bbox #(
    .TILE_WIDTH   (TILE_WIDTH),
    .TILE_COLUMNS (TILE_COLUMNS),
    .TILE_ROWS    (TILE_ROWS)
  ) u_bbox (
    .p0     (p0),
    .p1     (p1),
    .p2     (p2),
    .min_tx (min_tx),
    .max_tx (max_tx),
    .min_ty (min_ty),
    .max_ty (max_ty),
    .cull   (cull)
  );

  assign in_rdy = (state == IDLE);
  assign last_x = (out_meta.tile_x == max_tx_r);
  assign last_y = (out_meta.tile_y == max_ty_r);

  // The output registers double as the triangle holding registers and tile counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      out_vld  <= 1'b0;
      tri_done <= 1'b0;
      out_meta <= '0;
      out_v0   <= '0;
      out_v1   <= '0;
      out_v2   <= '0;
      min_tx_r <= '0;
      max_tx_r <= '0;
      max_ty_r <= '0;
    end else begin
      tri_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_vld) begin
            out_v0   <= in_v0;
            out_v1   <= in_v1;
            out_v2   <= in_v2;
            out_meta <= '{color: in_color, padding: 3'b000, tile_y: '0, tile_x: '0};
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cull) begin
            tri_done <= 1'b1;
            state    <= IDLE;
          end else begin
            min_tx_r        <= min_tx;
            max_tx_r        <= max_tx;
            max_ty_r        <= max_ty;
            out_meta.tile_x <= min_tx;
            out_meta.tile_y <= min_ty;
            out_vld         <= 1'b1;
            state           <= EMIT;
          end
        end
        EMIT: begin
          if (out_rdy) begin
            if (last_x && last_y) begin
              out_vld  <= 1'b0;
              tri_done <= 1'b1;
              state    <= IDLE;
            end else if (last_x) begin
              out_meta.tile_x <= min_tx_r;
              out_meta.tile_y <= out_meta.tile_y + TILE_Y_W'(1);
            end else begin
              out_meta.tile_x <= out_meta.tile_x + TILE_X_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_binner.sv
// Directed self-checking bench for tile_binner (default tile geometry 32px, 20x15).
module tb_tile_binner;
  import raster_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_vld;
  logic               in_rdy;
  coord_3d_t          in_v0, in_v1, in_v2;
  logic [COLOR_W-1:0] in_color;
  logic               out_vld;
  logic               out_rdy;
  coord_3d_t          out_v0, out_v1, out_v2;
  polygon_t           out_meta;
  logic               tri_done;

  tile_binner dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_v0    (in_v0),
    .in_v1    (in_v1),
    .in_v2    (in_v2),
    .in_color (in_color),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_v0   (out_v0),
    .out_v1   (out_v1),
    .out_v2   (out_v2),
    .out_meta (out_meta),
    .tri_done (tri_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int        rec_tx[$];
  int        rec_ty[$];
  int        rec_col[$];
  int        first_vld, done_cyc, hold_bad, stall_seen, pad_bad;
  bit        rdy_at_done, vld_at_done;
  coord_3d_t rec_v0, rec_v1, rec_v2;

  function automatic coord_3d_t mk(input int x, input int y);
    coord_3d_t c;
    c.x = COORD_W'(x);
    c.y = COORD_W'(y);
    c.z = Z_W'(x + y + 1);
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one triangle and logs every transferred record; cycle 1 is the SETUP cycle.
  task automatic run_tri(input coord_3d_t a, input coord_3d_t b, input coord_3d_t c,
                         input logic [COLOR_W-1:0] col, input int stall);
    int       n;
    int       stall_left;
    polygon_t held;
    rec_tx.delete(); rec_ty.delete(); rec_col.delete();
    first_vld = -1; done_cyc = -1; hold_bad = 0; stall_seen = 0; pad_bad = 0;
    rdy_at_done = 1'b0; vld_at_done = 1'b0; stall_left = 0;
    in_v0 = a; in_v1 = b; in_v2 = c; in_color = col; in_vld = 1'b1; out_rdy = 1'b1;
    n = 0;
    while (!in_rdy && n < 50) begin step(); n++; end
    step();
    in_vld = 1'b0; in_v0 = '0; in_v1 = '0; in_v2 = '0; in_color = '0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (tri_done) begin
        done_cyc = cyc; rdy_at_done = in_rdy; vld_at_done = out_vld;
        break;
      end
      if (out_vld) begin
        if (first_vld < 0) begin
          first_vld = cyc; stall_left = stall; held = out_meta;
          rec_v0 = out_v0; rec_v1 = out_v1; rec_v2 = out_v2;
        end
        if (stall_left > 0) begin
          out_rdy = 1'b0;
          stall_seen++;
          if (out_meta !== held || out_v0 !== rec_v0 || out_v2 !== rec_v2) hold_bad++;
          stall_left--;
        end else begin
          out_rdy = 1'b1;
          rec_tx.push_back(int'(out_meta.tile_x));
          rec_ty.push_back(int'(out_meta.tile_y));
          rec_col.push_back(int'(out_meta.color));
          if (out_meta.padding !== 3'b000) pad_bad++;
        end
      end
      step();
    end
    out_rdy = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
    in_v0 = mk(5, 5); in_v1 = mk(6, 6); in_v2 = mk(7, 7); in_color = 4'hA;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_out_vld got=%b want=0", out_vld); end
    checks++; if (tri_done !== 1'b0) begin failures++; $display("FAIL reset_tri_done got=%b want=0", tri_done); end
    checks++; if (out_meta !== 16'h0) begin failures++; $display("FAIL reset_out_meta got=%h want=0", out_meta); end
    checks++; if (out_v0 !== '0 || out_v1 !== '0 || out_v2 !== '0) begin failures++; $display("FAIL reset_out_v got=%h/%h/%h want=0", out_v0, out_v1, out_v2); end
    rst_n = 1'b1;
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL reset_in_rdy got=%b want=1", in_rdy); end
  endtask

  task automatic test_single();
    run_tri(mk(10, 10), mk(20, 10), mk(10, 20), 4'd5, 0);
    checks++; if (rec_tx.size() != 1) begin failures++; $display("FAIL single_count got=%0d want=1", rec_tx.size()); end
    if (rec_tx.size() == 1) begin
      checks++; if (rec_tx[0] != 0 || rec_ty[0] != 0) begin failures++; $display("FAIL single_tile got=(%0d,%0d) want=(0,0)", rec_tx[0], rec_ty[0]); end
      checks++; if (rec_col[0] != 5) begin failures++; $display("FAIL single_color got=%0d want=5", rec_col[0]); end
    end
    checks++; if (first_vld != 2) begin failures++; $display("FAIL single_latency got=%0d want=2", first_vld); end
    checks++; if (done_cyc != 3) begin failures++; $display("FAIL single_done_cycle got=%0d want=3", done_cyc); end
    checks++; if (!rdy_at_done || vld_at_done) begin failures++; $display("FAIL single_done_state in_rdy=%b out_vld=%b want 1/0", rdy_at_done, vld_at_done); end
    checks++; if (rec_v0 !== mk(10, 10) || rec_v1 !== mk(20, 10) || rec_v2 !== mk(10, 20)) begin failures++; $display("FAIL single_vertices got=%h/%h/%h want=%h/%h/%h", rec_v0, rec_v1, rec_v2, mk(10, 10), mk(20, 10), mk(10, 20)); end
    checks++; if (pad_bad != 0) begin failures++; $display("FAIL single_padding nonzero_records=%0d want=0", pad_bad); end
  endtask

  task automatic check_seq(input string name, input int ex[$], input int ey[$], input int col);
    checks++; if (rec_tx.size() != ex.size()) begin failures++; $display("FAIL %s_count got=%0d want=%0d", name, rec_tx.size(), ex.size()); end
    else begin
      for (int i = 0; i < ex.size(); i++) begin
        checks++;
        if (rec_tx[i] != ex[i] || rec_ty[i] != ey[i] || rec_col[i] != col) begin
          failures++;
          $display("FAIL %s_rec%0d got=(%0d,%0d,c%0d) want=(%0d,%0d,c%0d)", name, i, rec_tx[i], rec_ty[i], rec_col[i], ex[i], ey[i], col);
        end
      end
    end
  endtask

  task automatic test_multi();
    run_tri(mk(30, 30), mk(70, 30), mk(30, 40), 4'd9, 0);
    check_seq("multi", '{0, 1, 2, 0, 1, 2}, '{0, 0, 0, 1, 1, 1}, 9);
    checks++; if (done_cyc != 8) begin failures++; $display("FAIL multi_done_cycle got=%0d want=8", done_cyc); end
  endtask

  task automatic test_back_pressure();
    run_tri(mk(30, 30), mk(70, 30), mk(30, 40), 4'd3, 5);
    checks++; if (stall_seen != 5) begin failures++; $display("FAIL stall_cycles got=%0d want=5", stall_seen); end
    checks++; if (hold_bad != 0) begin failures++; $display("FAIL stall_hold changed_cycles=%0d want=0", hold_bad); end
    check_seq("stall", '{0, 1, 2, 0, 1, 2}, '{0, 0, 0, 1, 1, 1}, 3);
    checks++; if (done_cyc != 13) begin failures++; $display("FAIL stall_done_cycle got=%0d want=13", done_cyc); end
  endtask

  task automatic test_offscreen_cull();
    run_tri(mk(640, 0), mk(700, 10), mk(650, 20), 4'd1, 0);
    checks++; if (first_vld != -1 || rec_tx.size() != 0) begin failures++; $display("FAIL cull_x_records got=%0d want=0", rec_tx.size()); end
    checks++; if (done_cyc != 2 || !rdy_at_done) begin failures++; $display("FAIL cull_x_done got=cyc%0d rdy%b want=cyc2 rdy1", done_cyc, rdy_at_done); end
    run_tri(mk(0, 480), mk(10, 490), mk(5, 500), 4'd1, 0);
    checks++; if (first_vld != -1 || rec_tx.size() != 0) begin failures++; $display("FAIL cull_y_records got=%0d want=0", rec_tx.size()); end
    checks++; if (done_cyc != 2 || !rdy_at_done) begin failures++; $display("FAIL cull_y_done got=cyc%0d rdy%b want=cyc2 rdy1", done_cyc, rdy_at_done); end
  endtask

  task automatic test_clamp();
    run_tri(mk(600, 0), mk(1000, 5), mk(600, 10), 4'd7, 0);
    check_seq("clamp_x", '{18, 19}, '{0, 0}, 7);
    run_tri(mk(0, 400), mk(40, 400), mk(0, 1000), 4'd2, 0);
    check_seq("clamp_y", '{0, 1, 0, 1, 0, 1}, '{12, 12, 13, 13, 14, 14}, 2);
    run_tri(mk(620, 460), mk(630, 465), mk(625, 470), 4'd15, 0);
    check_seq("corner", '{19}, '{14}, 15);
  endtask

  task automatic test_winding();
    run_tri(mk(10, 10), mk(10, 20), mk(20, 10), 4'd6, 0);
`ifdef BINNER_BACKFACE_CULL_EN
    checks++; if (rec_tx.size() != 0) begin failures++; $display("FAIL winding_records got=%0d want=0", rec_tx.size()); end
    checks++; if (done_cyc != 2) begin failures++; $display("FAIL winding_done_cycle got=%0d want=2", done_cyc); end
`else
    check_seq("winding", '{0}, '{0}, 6);
    checks++; if (done_cyc != 3) begin failures++; $display("FAIL winding_done_cycle got=%0d want=3", done_cyc); end
`endif
  endtask

  task automatic test_reset_mid_emit();
    int  xfers;
    bit  hit;
    int  bad_done, bad_vld;
    xfers = 0; hit = 1'b0; bad_done = 0; bad_vld = 0;
    in_v0 = mk(30, 30); in_v1 = mk(70, 30); in_v2 = mk(30, 40); in_color = 4'd4;
    in_vld = 1'b1; out_rdy = 1'b1;
    step();
    in_vld = 1'b0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      if (out_vld) begin
        if (xfers == 2) begin hit = 1'b1; rst_n = 1'b0; break; end
        xfers++;
      end
      step();
    end
    step();
    checks++; if (!hit) begin failures++; $display("FAIL abort_third_record not reached want=reached"); end
    checks++; if (out_vld !== 1'b0 || tri_done !== 1'b0) begin failures++; $display("FAIL abort_outputs out_vld=%b tri_done=%b want=0/0", out_vld, tri_done); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (tri_done !== 1'b0) bad_done++;
      if (out_vld !== 1'b0) bad_vld++;
      step();
    end
    checks++; if (bad_done != 0 || bad_vld != 0) begin failures++; $display("FAIL abort_quiet tri_done_cycles=%0d out_vld_cycles=%0d want=0/0", bad_done, bad_vld); end
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL abort_in_rdy got=%b want=1", in_rdy); end
    run_tri(mk(100, 40), mk(120, 40), mk(100, 60), 4'd11, 0);
    check_seq("after_abort", '{3}, '{1}, 11);
    checks++; if (done_cyc != 3) begin failures++; $display("FAIL after_abort_done got=%0d want=3", done_cyc); end
  endtask

  initial begin
    test_reset();
    step();
    test_single();
    test_multi();
    test_back_pressure();
    test_offscreen_cull();
    test_clamp();
    test_winding();
    test_reset_mid_emit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tile_binner.md
TILE_BINNER -- requirements
Module: tile_binner

Interface
REQ-001 SHALL have parameters: TILE_WIDTH, default 32, tile edge in pixels; TILE_COLUMNS, default 20, tiles per row; TILE_ROWS, default 15, tile rows per frame.
REQ-002 SHALL have ports, clock and reset first:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- in_vld  input  1  triangle valid
- in_rdy  output  1  binner accepts a triangle
- in_v0, in_v1, in_v2  input  coord_3d_t (28 each)  screen-space vertices
- in_color  input  4  polygon color
- out_vld  output  1  tile record valid
- out_rdy  input  1  rasterizer ready (driven by rasterizer rdy_out)
- out_v0, out_v1, out_v2  output  coord_3d_t  vertices passed through
- out_meta  output  polygon_t (16)  color, padding, tile_y, tile_x
- tri_done  output  1  one-cycle pulse when a triangle is finished or culled

Function
REQ-003 SHALL be the producer for the rasterizer triangle input: it emits one record per screen tile overlapped by the triangle bounding box.
REQ-004 SHALL use states IDLE, SETUP and EMIT: IDLE -> SETUP on in_vld&&in_rdy; SETUP -> EMIT or, if culled, -> IDLE; EMIT -> IDLE when the final tile transfers.
REQ-005 in_rdy SHALL equal (state==IDLE); input fields are registered on the accepting edge.
REQ-006 SETUP SHALL last exactly one cycle and compute bbox min/max x,y from the registered vertices; tile index = coordinate >> log2(TILE_WIDTH).
REQ-007 Max tile_x SHALL clamp to TILE_COLUMNS-1 and max tile_y to TILE_ROWS-1.
REQ-008 Off-screen cull: min x >= TILE_WIDTH*TILE_COLUMNS or min y >= TILE_WIDTH*TILE_ROWS SHALL emit no record.
REQ-009 out_vld SHALL assert on the cycle after SETUP; first record latency is 2 cycles after the input handshake edge.
REQ-010 SHALL emit tiles in raster order: tile_x from min to max, then tile_y+1 with tile_x back to min.
REQ-011 While out_vld && !out_rdy, all out_* SHALL hold stable; the tile counter advances only on out_vld&&out_rdy.
REQ-012 out_meta.padding SHALL be 3'b000; out_meta.color = registered in_color; out_v* = registered vertices.
REQ-013 tri_done SHALL pulse in the cycle after the final transfer, or in the cycle after a culling SETUP; the state is IDLE and in_rdy is 1 in that same cycle.
REQ-014 A degenerate bbox (all vertices in one tile) SHALL emit exactly one record.

Reset
REQ-015 While rst_n=0 at a clock edge: state=IDLE, out_vld=0, tri_done=0, tile counters=0, out_meta=0, out_v*=0; in_rdy=1 from the first cycle after reset.
REQ-016 Reset during EMIT SHALL abandon the triangle without a tri_done pulse; no partial record remains.

Configuration
REQ-017 Macro BINNER_BACKFACE_CULL_EN: when defined, SETUP SHALL compute signed area A = (v1.x-v0.x)*(v2.y-v0.y) - (v2.x-v0.x)*(v1.y-v0.y) using 11-bit signed differences and a 23-bit signed result, and SHALL cull the triangle if A <= 0; when undefined, no area logic exists and only the REQ-008 cull applies.

Structure
REQ-018 coord_3d_t, coord_2d_t, polygon_t and the tile constants SHALL live in shared package raster_pkg, which is also used by the rasterizer.
REQ-019 Bbox, clamp and cull logic SHALL be a combinational sub-module tile_bbox; the FSM, counters and output registers reside in tile_binner.

Verification
REQ-020 Vertices (10,10),(20,10),(10,20), color 5, out_rdy=1 -> one record, tile (0,0), color 5; tri_done one cycle later.
REQ-021 Vertices (30,30),(70,30),(30,40) -> six records in order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
REQ-022 Same as REQ-021 with out_rdy=0 for 5 cycles after the first out_vld -> record (0,0) held stable 5 cycles, then the sequence continues unchanged.
REQ-023 All vertices with x>=640 -> no out_vld, tri_done 2 cycles after accept, in_rdy=1; vertex x=1000, y=5 with others at (600,0),(600,10) -> tiles x 18..19 only.
REQ-024 Vertices (10,10),(10,20),(20,10): macro defined -> culled, no records; macro undefined -> one record at tile (0,0).
REQ-025 rst_n=0 asserted on the third record of REQ-021 -> out_vld=0 next cycle, no tri_done, next triangle processed normally.
